serial_subtractor: RTL and testbench

// - Bit-serial unsigned subtractor: accepts operands a, b over a valid/ready handshake and computes a - b.
// - Processes one bit per clock, LSB first, through a single full-subtractor cell.
// - Returns diff and borrow over a second valid/ready handshake.
// - Low-area counterpart to the parallel ripple adder in the arithmetic library.

---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 94 +++++++++
 tb/tb_serial_subtractor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic package: FSM state encoding and width helpers
// for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } sub_state_t;

  localparam int DEF_WIDTH = 4;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, bout on underflow.
// Combinational mirror of full_adder.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, valid/ready on both sides.
// Define SERIAL_SUB_SAT_EN to clamp diff to 0 when a < b.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = cnt_width(WIDTH);

  sub_state_t       state;
  sub_state_t       state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_msb;
  logic [WIDTH-1:0] diff_nx;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             bout;
  logic             accept;
  logic             last;

  // borrow doubles as the serial borrow-in while BUSY
  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow),
    .d    (d),
    .bout (bout)
  );

  assign in_ready  = (state == IDLE) & rst_n;
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign last      = (state == BUSY) &&
                     (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = BUSY;
      BUSY:    if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_comb begin
    d_msb            = '0;
    d_msb[WIDTH-1]   = d;
    diff_nx          = (diff >> 1) | d_msb;
`ifdef SERIAL_SUB_SAT_EN
    if (last && bout) diff_nx = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      diff   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      diff   <= diff_nx;
      borrow <= bout;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with a cycle-level reference
// model; honours SERIAL_SUB_SAT_EN when defined.
module tb_serial_subtractor;

  localparam int WIDTH = 4;
`ifdef SERIAL_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  function automatic logic [WIDTH:0] model(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    logic             br;
    r  = x - y;
    br = (x < y);
    if (SAT && br) r = '0;
    return {r, br};
  endfunction

  function automatic int lit(input int dv, input int bv);
    return (SAT && bv != 0) ? 0 : dv;
  endfunction

  // reference: one op in flight, result due WIDTH+1 negedges after accept
  logic             busy_m = 1'b0;
  int               acc_cyc = 0;
  logic [WIDTH-1:0] exp_d = '0;
  logic             exp_b = 1'b0;
  logic             ov_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_m = 1'b0;
    end else begin
      ov_exp = busy_m && (cyc - acc_cyc >= WIDTH + 1);
      chk("mon in_ready", int'(in_ready), int'(!busy_m));
      chk("mon out_valid", int'(out_valid), int'(ov_exp));
      if (out_valid && ov_exp) begin
        chk("mon diff", int'(diff), int'(exp_d));
        chk("mon borrow", int'(borrow), int'(exp_b));
      end
      if (in_valid && in_ready) begin
        busy_m  = 1'b1;
        acc_cyc = cyc;
        {exp_d, exp_b} = model(a, b);
      end else if (out_valid && out_ready) begin
        busy_m = 1'b0;
      end
    end
  end

  task automatic wait_accept(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (in_ready && in_valid) begin
        @(posedge clk);
        #2;
        done = 1'b1;
      end
    end
    if (!done) chk({nm, " accept_timeout"}, 0, 1);
  endtask

  task automatic xact(input int x, input int y, input string nm);
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    a        = WIDTH'(x);
    b        = WIDTH'(y);
    wait_accept(nm);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int ed, input int eb, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      chk({nm, " out_timeout"}, 0, 1);
    end else begin
      chk({nm, " diff"}, int'(diff), ed);
      chk({nm, " borrow"}, int'(borrow), eb);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] held;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;

    chk("model 5-3", int'(model(4'd5, 4'd3)), {2, 1'b0});
    chk("model 0-15", int'(model(4'd0, 4'd15)),
        (lit(1, 1) << 1) | 1);

    repeat (2) @(posedge clk);
    #2;
    chk("rst in_ready", int'(in_ready), 0);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst diff", int'(diff), 0);
    chk("rst borrow", int'(borrow), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst in_ready", int'(in_ready), 1);

    xact(5, 3, "5-3");
    wait_out(2, 0, "5-3");
    @(negedge clk);
    chk("5-3 ready_back", int'(in_ready), 1);

    xact(3, 5, "3-5");    wait_out(lit(14, 1), 1, "3-5");
    xact(0, 0, "0-0");    wait_out(0, 0, "0-0");
    xact(15, 15, "15-15"); wait_out(0, 0, "15-15");
    xact(0, 15, "0-15");  wait_out(lit(1, 1), 1, "0-15");
    xact(15, 0, "15-0");  wait_out(15, 0, "15-0");

    // back-pressure with an ignored operand pulse
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    xact(10, 4, "bp");
    wait_out(6, 0, "bp");
    held = diff;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      in_valid = (i == 1);
      a        = 4'd9;
      b        = 4'd1;
      @(negedge clk);
      chk("bp out_valid", int'(out_valid), 1);
      chk("bp held", int'(diff), int'(held));
      chk("bp in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #2;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp no_extra", int'(out_valid), 0);

    // reset during the second BUSY cycle
    xact(12, 3, "rst_mid");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rmid in_ready", int'(in_ready), 0);
    chk("rmid out_valid", int'(out_valid), 0);
    chk("rmid diff", int'(diff), 0);
    chk("rmid borrow", int'(borrow), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rmid no_residual", int'(out_valid), 0);
    xact(7, 2, "7-2");
    wait_out(5, 0, "7-2");

    // back-to-back with in_valid held high
    fork
      begin
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        a        = 4'd8;
        b        = 4'd1;
        wait_accept("b2b1");
        a = 4'd1;
        b = 4'd8;
        wait_accept("b2b2");
        in_valid = 1'b0;
      end
      begin
        wait_out(7, 0, "b2b 8-1");
        wait_out(lit(9, 1), 1, "b2b 1-8");
      end
    join

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
